// File: rtl/regfile_pkg.sv
// Shared constants and state encoding for the register-file write-port scheduler.
package regfile_pkg;

    localparam int AW   = 2;
    localparam int DW   = 4;
    localparam int NREG = 4;

    localparam logic ST_INIT = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    typedef enum logic {
        S_INIT = ST_INIT,
        S_RUN  = ST_RUN
    } state_e;

endpackage

// File: rtl/regfile_write_sched_rr_arb2.sv
// Two-way round-robin arbiter: the requester not granted most recently wins a tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic       ptr
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt[0] = req[0] & (~req[1] | ~ptr_q);
        gnt[1] = req[1] & (~req[0] |  ptr_q);
        ptr_d  = ptr_q;
        if (gnt[0]) begin
            ptr_d = 1'b1;
        end else if (gnt[1]) begin
            ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/regfile_write_sched.sv
// Write-port scheduler: clears the register file after reset, then shares its
// single write port between two valid/ready requesters in round-robin order.
//
//   state  | meaning
//   S_INIT | issuing one clear write per cycle, readies held low
//   S_RUN  | arbitrating requesters, init_done high
module regfile_write_sched
    import regfile_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_data,
    output logic          req1_ready,
    output logic [AW-1:0] rf_rw,
    output logic [DW-1:0] rf_dw,
    output logic          rf_rwe,
    output logic          init_done
);

    localparam int CW = AW + 1;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rwe_q, rwe_d;
    logic [AW-1:0] rw_q, rw_d;
    logic [DW-1:0] dw_q, dw_d;

    logic [1:0]    arb_req;
    logic [1:0]    gnt;
    logic          unused_ptr;

    // Requests are masked during reset so nothing is accepted that would be discarded.
    assign arb_req = {req1_valid, req0_valid} & {2{(state_q == S_RUN) && !rst}};

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req (arb_req),
        .gnt (gnt),
        .ptr (unused_ptr)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rwe_d   = 1'b0;
        rw_d    = rw_q;
        dw_d    = dw_q;
        unique case (state_q)
            S_INIT: begin
                // The counter stops one past the last register so init_done rises
                // only after the final clear has been presented to the file.
                if (cnt_q == CW'(NREG)) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    rwe_d = 1'b1;
                    rw_d  = cnt_q[AW-1:0];
                    dw_d  = '0;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RUN: begin
                if (gnt[0]) begin
                    rwe_d = 1'b1;
                    rw_d  = req0_addr;
                    dw_d  = req0_data;
                end else if (gnt[1]) begin
                    rwe_d = 1'b1;
                    rw_d  = req1_addr;
                    dw_d  = req1_data;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
            rwe_q   <= 1'b0;
            rw_q    <= '0;
            dw_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rwe_q   <= rwe_d;
            rw_q    <= rw_d;
            dw_q    <= dw_d;
        end
    end

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];
    assign rf_rwe     = rwe_q;
    assign rf_rw      = rw_q;
    assign rf_dw      = dw_q;
    assign init_done  = (state_q == S_RUN);

endmodule
